fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-slot instruction fetch stage.
//
// A program counter drives instruction memory combinationally; each edge in
// RUN with a free slot captures the addressed word into the instruction
// register (ir/ir_pc/ir_valid) and advances the pc. A captured word whose
// opcode equals HALT_OPCODE stops further fetching. A redirect flushes the
// slot and restarts fetching at redirect_pc from any state.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        pulse, leaves IDLE for RUN
//   imem_addr    instruction memory read address (== pc)
//   imem_instr   instruction memory read data (combinational from imem_addr)
//   ir, ir_pc    instruction register and the address it came from
//   ir_valid     ir holds an unconsumed instruction
//   ir_ready     decode accepts ir this cycle
//   redirect     branch/jump request, highest priority
//   redirect_pc  branch/jump target
//   halted       FSM is in HALT
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] imem_addr,
    input  logic [23:0] imem_instr,
    output logic [23:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [23:0] ir_q, ir_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        slot_free;

    // The slot is free if empty or being drained by decode this cycle.
    assign slot_free = !ir_valid_q || ir_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        if (redirect) begin
            // Flush regardless of ir_ready; no capture in the redirect cycle.
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
            state_d    = StRun;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (slot_free) begin
                        ir_d       = imem_instr;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + 16'd1;
                        if (imem_instr[23:20] == HALT_OPCODE) begin
                            state_d = StHalt;
                        end
                    end
                end
                StHalt: begin
                    // The halt word stays presented until decode takes it.
                    if (ir_valid_q && ir_ready) begin
                        ir_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            ir_q       <= 24'h0;
            ir_pc_q    <= 16'h0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase. Expected
// instruction streams are pushed into a queue whenever fetching (re)starts at
// an address; a negedge monitor pops and compares each word decode consumes.
module tb_fetch_unit;

    localparam logic [15:0] RP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] imem_addr;
    logic [23:0] imem_instr;
    logic [23:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    logic [23:0] mem [0:65535];
    assign imem_instr = mem[imem_addr];

    fetch_unit #(
        .RESET_PC    (RP),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [23:0] w;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic        model_idle;
    logic        reload_pending;
    logic [15:0] reload_addr;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Words fetched sequentially from a, up to and including the first halt word.
    task automatic load_stream(input logic [15:0] a);
        logic [15:0] p;
        p = a;
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back({p, mem[p]});
            if (mem[p][23:20] == 4'hF) break;
            p = p + 16'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reload_pending) begin
            load_stream(reload_addr);
            reload_pending = 1'b0;
        end
    endtask

    task automatic do_redirect(input logic [15:0] a);
        redirect       = 1'b1;
        redirect_pc    = a;
        reload_pending = 1'b1;
        reload_addr    = a;
        model_idle     = 1'b0;
        tick();
        redirect = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        if (model_idle) begin
            reload_pending = 1'b1;
            reload_addr    = RP;
            model_idle     = 1'b0;
        end
        tick();
        start = 1'b0;
    endtask

    // Scoreboard monitor: every accepted ir must be the next expected word.
    always @(negedge clk) begin
        if (!rst && ir_valid && ir_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL consume: got %h@%h want nothing", ir, ir_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ir_pc, ir} !== mon_e) begin
                    bad++;
                    $display("FAIL consume: got %h@%h want %h@%h", ir, ir_pc, mon_e.w, mon_e.pc);
                end
            end
        end
    end

    initial begin
        logic [23:0] w;
        logic [15:0] tgt;
        for (int i = 0; i < 65536; i++) begin
            w = 24'($urandom);
            if (w[23:20] == 4'hF) w[23:20] = 4'h1;
            mem[i] = w;
        end
        mem[0]     = 24'hc10005;
        mem[1]     = 24'hd20004;
        mem[2]     = 24'h131200;
        mem[3]     = 24'hF00000;
        mem[16'h30] = 24'hF12345;
        mem[16'h68] = 24'hF00001;

        rst = 1'b1; start = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        model_idle = 1'b1; reload_pending = 1'b0; reload_addr = RP;
        #12;
        check("rst_addr", 40'(imem_addr), 40'(RP));
        check("rst_ir", 40'(ir), 40'h0);
        check("rst_ir_pc", 40'(ir_pc), 40'h0);
        check("rst_valid", 40'(ir_valid), 40'h0);
        check("rst_halted", 40'(halted), 40'h0);
        rst = 1'b0;

        // Idle without start: nothing fetched.
        ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_valid", 40'(ir_valid), 40'h0);
            check("idle_addr", 40'(imem_addr), 40'(RP));
        end

        // Sequential fetch up to the halt word.
        do_start();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("seq_addr", 40'(imem_addr), 40'(i + 1));
            check("seq_ir", 40'(ir), 40'(mem[i]));
            check("seq_ir_pc", 40'(ir_pc), 40'(i));
            check("seq_valid", 40'(ir_valid), 40'h1);
        end
        check("halt_set", 40'(halted), 40'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("halt_valid", 40'(ir_valid), 40'h0);
            check("halt_addr", 40'(imem_addr), 40'h4);
            check("halt_stay", 40'(halted), 40'h1);
        end

        // Redirect out of HALT, then stall.
        ir_ready = 1'b0;
        do_redirect(16'h0000);
        check("redir_halted", 40'(halted), 40'h0);
        check("redir_valid", 40'(ir_valid), 40'h0);
        check("redir_addr", 40'(imem_addr), 40'h0);
        tick();
        check("first_ir", 40'(ir), 40'hc10005);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 40'(ir_valid), 40'h1);
            check("stall_ir", 40'(ir), 40'hc10005);
            check("stall_addr", 40'(imem_addr), 40'h1);
        end
        ir_ready = 1'b1;
        tick();
        check("unstall_ir", 40'(ir), 40'hd20004);
        check("unstall_ir_pc", 40'(ir_pc), 40'h1);
        ir_ready = 1'b0;

        // Redirect flushes a stalled word.
        do_redirect(16'h0040);
        check("flush_valid", 40'(ir_valid), 40'h0);
        check("flush_addr", 40'(imem_addr), 40'h40);
        tick();
        check("tgt_ir", 40'(ir), 40'(mem[16'h40]));
        check("tgt_ir_pc", 40'(ir_pc), 40'h40);

        // pc wraps at 16'hFFFF.
        ir_ready = 1'b1;
        do_redirect(16'hFFFF);
        check("wrap_addr", 40'(imem_addr), 40'hFFFF);
        tick();
        check("wrap_pc0", 40'(ir_pc), 40'hFFFF);
        check("wrap_ir0", 40'(ir), 40'(mem[16'hFFFF]));
        tick();
        check("wrap_pc1", 40'(ir_pc), 40'h0000);
        check("wrap_ir1", 40'(ir), 40'hc10005);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 40'(ir_valid), 40'h0);
        check("arst_addr", 40'(imem_addr), 40'(RP));
        check("arst_ir", 40'(ir), 40'h0);
        check("arst_ir_pc", 40'(ir_pc), 40'h0);
        check("arst_halted", 40'(halted), 40'h0);
        #1 rst = 1'b0;
        exp_q.delete();
        model_idle = 1'b1;
        reload_pending = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", 40'(ir_valid), 40'h0);
            check("post_rst_addr", 40'(imem_addr), 40'(RP));
        end

        // Randomized traffic: ready, redirects, and spurious starts.
        for (int c = 0; c < 600; c++) begin
            ir_ready = ($urandom_range(0, 9) < 7);
            start    = ($urandom_range(0, 9) == 0);
            redirect = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 16'hFFF0 + 16'($urandom_range(0, 15));
            else tgt = 16'($urandom_range(0, 16'h7F));
            redirect_pc = tgt;
            if (redirect) begin
                reload_pending = 1'b1;
                reload_addr    = tgt;
                model_idle     = 1'b0;
            end else if (start && model_idle) begin
                reload_pending = 1'b1;
                reload_addr    = RP;
                model_idle     = 1'b0;
            end
            tick();
            start    = 1'b0;
            redirect = 1'b0;
        end

        ir_ready = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
